// File: rtl/proc_pkg.sv
// Shared processor definitions: controller state encoding, opcodes and ALU selects.
// Imported by the control unit, datapath and ALU.
package proc_pkg;

  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Undefined opcodes fall through to NOOP.
  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_STORE: return ST_STORE;
      OP_LOAD:  return ST_LOAD_A;
      OP_ADD:   return ST_ADD;
      OP_SUB:   return ST_SUB;
      OP_HALT:  return ST_HALT;
      default:  return ST_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit, the instruction ROM and the datapath.
// The control unit is the master; ROM/datapath side is the slave.
interface control_unit_if #(parameter int PC_W = 7);

  logic [15:0]     IR_in;
  logic [PC_W-1:0] PC_Addr;
  logic [7:0]      D_Addr;
  logic            D_wr;
  logic            RF_s;
  logic            RF_W_en;
  logic [3:0]      RF_W_addr;
  logic [3:0]      RF_Ra_addr;
  logic [3:0]      RF_Rb_addr;
  logic [2:0]      Alu_s0;
  logic [3:0]      State;
  logic            Halted;

  modport master (
    input  IR_in,
    output PC_Addr, D_Addr, D_wr, RF_s, RF_W_en, RF_W_addr,
           RF_Ra_addr, RF_Rb_addr, Alu_s0, State, Halted
  );

  modport slave (
    output IR_in,
    input  PC_Addr, D_Addr, D_wr, RF_s, RF_W_en, RF_W_addr,
           RF_Ra_addr, RF_Rb_addr, Alu_s0, State, Halted
  );

endinterface

// File: rtl/program_counter.sv
// Program counter with synchronous clear and increment; wraps naturally at 2^PC_W.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_reg;

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      pc_reg <= '0;
    end else if (inc) begin
      pc_reg <= pc_reg + PC_W'(1);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer: fetches from a synchronous ROM, decodes the opcode
// and drives the datapath control lines from the state and instruction register only.
module control_unit
  import proc_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic          Clk,
  input  logic          Reset,
  control_unit_if.master bus
);

  state_t          state_reg;
  state_t          state_next;
  logic [15:0]     ir_reg;
  logic [PC_W-1:0] pc;

  program_counter #(.PC_W(PC_W)) u_pc (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state_reg == ST_INIT),
    .inc   (state_reg == ST_FETCH),
    .pc    (pc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || state_reg == ST_INIT) begin
      ir_reg <= '0;
    end else if (state_reg == ST_FETCH) begin
      ir_reg <= bus.IR_in;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:   state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = decode_op(ir_reg[15:12]);
      ST_LOAD_A: state_next = ST_LOAD_B;
      ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_INIT;
    endcase
  end

  // Memory read data is only valid in LOAD_B, so the RF write waits for it.
  always_comb begin
    bus.D_Addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_en    = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.Alu_s0     = ALU_PASS;
    case (state_reg)
      ST_LOAD_A: begin
        bus.D_Addr = ir_reg[11:4];
        bus.RF_s   = 1'b1;
      end
      ST_LOAD_B: begin
        bus.D_Addr    = ir_reg[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = ir_reg[3:0];
        bus.RF_W_en   = 1'b1;
      end
      ST_STORE: begin
        bus.D_Addr     = ir_reg[7:0];
        bus.RF_Ra_addr = ir_reg[11:8];
        bus.D_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        bus.RF_Ra_addr = ir_reg[11:8];
        bus.RF_Rb_addr = ir_reg[7:4];
        bus.RF_W_addr  = ir_reg[3:0];
        bus.RF_W_en    = 1'b1;
        bus.Alu_s0     = (state_reg == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign bus.PC_Addr = pc;
  assign bus.State   = state_reg;
  assign bus.Halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural ROM/RF/memory around the DUT, checked against
// an instruction-level model of the ISA and the per-state control table.
module tb_control_unit;

  localparam int PC_W  = 7;
  localparam int ROM_N = 1 << PC_W;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  control_unit_if #(.PC_W(PC_W)) bus();

  control_unit #(.PC_W(PC_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [15:0] rom     [ROM_N];
  logic [15:0] init_rf [16];
  logic [15:0] init_dm [256];
  logic [15:0] rf      [16];
  logic [15:0] dmem    [256];
  logic [15:0] rom_q;
  logic [15:0] mem_q;
  logic [15:0] alu_y;
  logic        load_env = 1'b0;

  int total = 0;
  int bad   = 0;

  assign bus.IR_in = rom_q;

  always_comb begin
    alu_y = rf[bus.RF_Ra_addr];
    if (bus.Alu_s0 == 3'd1) alu_y = rf[bus.RF_Ra_addr] + rf[bus.RF_Rb_addr];
    else if (bus.Alu_s0 == 3'd2) alu_y = rf[bus.RF_Ra_addr] - rf[bus.RF_Rb_addr];
  end

  // Synchronous ROM, synchronous data memory and register file of the datapath.
  always @(posedge Clk) begin
    rom_q <= rom[bus.PC_Addr];
    mem_q <= dmem[bus.D_Addr];
    if (load_env) begin
      rf   <= init_rf;
      dmem <= init_dm;
    end else begin
      if (bus.D_wr) dmem[bus.D_Addr] <= rf[bus.RF_Ra_addr];
      if (bus.RF_W_en) rf[bus.RF_W_addr] <= bus.RF_s ? mem_q : alu_y;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [26:0] obs();
    return {bus.D_Addr, bus.D_wr, bus.RF_s, bus.RF_W_en, bus.RF_W_addr,
            bus.RF_Ra_addr, bus.RF_Rb_addr, bus.Alu_s0, bus.Halted};
  endfunction

  // Control lines each state must show, straight from the per-state table.
  function automatic logic [26:0] exp_out(input int s, input logic [15:0] ir);
    logic [7:0] da = 8'd0;
    logic dw = 1'b0, rs = 1'b0, we = 1'b0, h = 1'b0;
    logic [3:0] wa = 4'd0, ra = 4'd0, rb = 4'd0;
    logic [2:0] alu = 3'd0;
    case (s)
      4: begin da = ir[11:4]; rs = 1'b1; end
      5: begin da = ir[11:4]; rs = 1'b1; wa = ir[3:0]; we = 1'b1; end
      6: begin da = ir[7:0]; ra = ir[11:8]; dw = 1'b1; end
      7: begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1; alu = 3'd1; end
      8: begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1; alu = 3'd2; end
      9: h = 1'b1;
      default: ;
    endcase
    return {da, dw, rs, we, wa, ra, rb, alu, h};
  endfunction

  function automatic logic [15:0] rand_noop();
    logic [31:0] r = $urandom();
    logic [3:0]  op = (r[31]) ? 4'd0 : 4'($urandom_range(6, 15));
    return {op, r[11:0]};
  endfunction

  // Resets, runs the ROM program cycle by cycle and compares the final RF/memory
  // with an instruction-level interpretation of the same program.
  task automatic run_program(input string name, input int max_instr);
    logic [15:0] m_rf [16];
    logic [15:0] m_dm [256];
    logic [15:0] ir;
    int pc = 0;
    int seq[$];
    bit halted = 0;
    m_rf = init_rf;
    m_dm = init_dm;
    Reset = 1'b1; load_env = 1'b1;
    step();
    Reset = 1'b0; load_env = 1'b0;
    total++;
    if (bus.State !== 4'd0 || bus.PC_Addr !== '0 || obs() !== 27'd0) begin
      bad++;
      $display("FAIL %s reset: State=%0d PC=%0d out=%h, want 0/0/0", name, bus.State, bus.PC_Addr, obs());
    end
    step();
    for (int n = 0; n < max_instr && !halted; n++) begin
      ir = rom[pc];
      total++;
      if (bus.State !== 4'd1 || bus.PC_Addr !== PC_W'(pc) || obs() !== 27'd0) begin
        bad++;
        $display("FAIL %s fetch#%0d: State=%0d PC=%0d out=%h, want 1/%0d/0", name, n, bus.State, bus.PC_Addr, obs(), pc);
      end
      pc = (pc + 1) % ROM_N;
      step();
      total++;
      if (bus.State !== 4'd2 || bus.PC_Addr !== PC_W'(pc) || obs() !== 27'd0) begin
        bad++;
        $display("FAIL %s decode#%0d: State=%0d PC=%0d out=%h, want 2/%0d/0", name, n, bus.State, bus.PC_Addr, obs(), pc);
      end
      step();
      case (ir[15:12])
        4'd1: seq = '{6};
        4'd2: seq = '{4, 5};
        4'd3: seq = '{7};
        4'd4: seq = '{8};
        4'd5: seq = '{9};
        default: seq = '{3};
      endcase
      foreach (seq[k]) begin
        total++;
        if (bus.State !== 4'(seq[k]) || obs() !== exp_out(seq[k], ir)) begin
          bad++;
          $display("FAIL %s exec ir=%h: State=%0d out=%h, want %0d/%h", name, ir, bus.State, obs(), seq[k], exp_out(seq[k], ir));
        end
        step();
      end
      case (ir[15:12])
        4'd1: m_dm[ir[7:0]] = m_rf[ir[11:8]];
        4'd2: m_rf[ir[3:0]] = m_dm[ir[11:4]];
        4'd3: m_rf[ir[3:0]] = m_rf[ir[11:8]] + m_rf[ir[7:4]];
        4'd4: m_rf[ir[3:0]] = m_rf[ir[11:8]] - m_rf[ir[7:4]];
        4'd5: halted = 1;
        default: ;
      endcase
    end
    if (halted) begin
      for (int c = 0; c < 20; c++) begin
        total++;
        if (bus.State !== 4'd9 || obs() !== exp_out(9, 16'h5000)) begin
          bad++;
          $display("FAIL %s halt hold c%0d: State=%0d out=%h, want 9/%h", name, c, bus.State, obs(), exp_out(9, 16'h5000));
        end
        step();
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rf[i] !== m_rf[i]) begin
        bad++;
        $display("FAIL %s R%0d: got %0d want %0d", name, i, rf[i], m_rf[i]);
      end
    end
    for (int i = 0; i < 256; i++) begin
      total++;
      if (dmem[i] !== m_dm[i]) begin
        bad++;
        $display("FAIL %s D[%0d]: got %0d want %0d", name, i, dmem[i], m_dm[i]);
      end
    end
    $display("run %s: %0d instr checked, halted=%0d", name, max_instr, halted);
  endtask

  task automatic clear_env();
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 16; i++) init_rf[i] = 16'(i * 7 + 1);
    for (int i = 0; i < 256; i++) init_dm[i] = 16'(i * 3 + 5);
  endtask

  task automatic test_reset();
    clear_env();
    Reset = 1'b1;
    step();
    step();
    total++;
    if (bus.State !== 4'd0 || bus.PC_Addr !== '0 || obs() !== 27'd0) begin
      bad++;
      $display("FAIL reset_state: State=%0d PC=%0d out=%h, want 0/0/0", bus.State, bus.PC_Addr, obs());
    end
    $display("test_reset done");
  endtask

  task automatic test_load();
    clear_env();
    rom[0] = 16'h2000; rom[1] = 16'h5000; init_dm[0] = 16'd123;
    run_program("load", 4);
    total++;
    if (rf[0] !== 16'd123) begin
      bad++;
      $display("FAIL load_r0: got %0d want 123", rf[0]);
    end
  endtask

  task automatic test_store();
    clear_env();
    rom[0] = 16'h1209; rom[1] = 16'h5000; init_rf[2] = 16'd222;
    run_program("store", 4);
    total++;
    if (dmem[9] !== 16'd222) begin
      bad++;
      $display("FAIL store_d9: got %0d want 222", dmem[9]);
    end
  endtask

  task automatic test_add_sub();
    clear_env();
    rom[0] = 16'h3123; rom[1] = 16'h4214; rom[2] = 16'h5000;
    init_rf[1] = 16'd123; init_rf[2] = 16'd222;
    run_program("add_sub", 5);
    total++;
    if (rf[3] !== 16'd345 || rf[4] !== 16'd99) begin
      bad++;
      $display("FAIL add_sub: R3=%0d R4=%0d want 345/99", rf[3], rf[4]);
    end
  endtask

  task automatic test_noop_wrap();
    clear_env();
    for (int i = 0; i < ROM_N; i++) rom[i] = rand_noop();
    rom[3] = 16'hF3A1;
    run_program("noop_wrap", ROM_N + 4);
  endtask

  task automatic test_halt();
    clear_env();
    rom[0] = 16'h0000; rom[1] = 16'h5000; rom[2] = 16'h3123;
    run_program("halt", 10);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++;
    if (bus.State !== 4'd0 || bus.Halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit: State=%0d Halted=%0d want 0/0", bus.State, bus.Halted);
    end
    step();
    total++;
    if (bus.State !== 4'd1 || bus.PC_Addr !== '0) begin
      bad++;
      $display("FAIL halt_refetch: State=%0d PC=%0d want 1/0", bus.State, bus.PC_Addr);
    end
  endtask

  task automatic test_reset_mid_add();
    clear_env();
    rom[0] = 16'h3123; rom[1] = 16'h5000;
    Reset = 1'b1; load_env = 1'b1;
    step();
    Reset = 1'b0; load_env = 1'b0;
    step(); step(); step();
    total++;
    if (bus.State !== 4'd7) begin
      bad++;
      $display("FAIL mid_add_reach: State=%0d want 7", bus.State);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    total++;
    if (bus.State !== 4'd0 || bus.PC_Addr !== '0 || bus.RF_W_en !== 1'b0 || bus.Alu_s0 !== 3'd0) begin
      bad++;
      $display("FAIL mid_add_reset: State=%0d PC=%0d we=%0d alu=%0d want 0/0/0/0", bus.State, bus.PC_Addr, bus.RF_W_en, bus.Alu_s0);
    end
    step();
    total++;
    if (bus.State !== 4'd1 || bus.PC_Addr !== '0) begin
      bad++;
      $display("FAIL mid_add_fetch: State=%0d PC=%0d want 1/0", bus.State, bus.PC_Addr);
    end
    step(); step();
    total++;
    if (bus.State !== 4'd7 || obs() !== exp_out(7, 16'h3123)) begin
      bad++;
      $display("FAIL mid_add_refetch: State=%0d out=%h want 7/%h", bus.State, obs(), exp_out(7, 16'h3123));
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] r;
    for (int t = 0; t < 6; t++) begin
      clear_env();
      for (int i = 0; i < 16; i++) init_rf[i] = 16'($urandom());
      for (int i = 0; i < 256; i++) init_dm[i] = 16'($urandom());
      for (int i = 0; i < 40; i++) begin
        r  = $urandom();
        op = 4'($urandom_range(0, 5));
        if (op == 4'd5) rom[i] = rand_noop();
        else rom[i] = {op, r[11:0]};
      end
      rom[40] = 16'h5000;
      run_program($sformatf("random%0d", t), 60);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_add_sub();
    test_noop_wrap();
    test_halt();
    test_reset_mid_add();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
